// File: rtl/tpu_pkg.sv
// tpu_pkg: definitions shared between the MAC array and the blocks around it.
//   ACC_W        - partial-sum width; the MAC acc_out width and the collector
//                  lane width must agree.
//   psum_state_e - state encoding of the partial-sum collector.
package tpu_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } psum_state_e;

endpackage : tpu_pkg

// File: rtl/psum_collector_skew_delay.sv
// skew_delay: enable-gated shift register used to remove the diagonal skew of
// one systolic column. With STAGES == 0 it degenerates to a wire.
//   clk, rst  - clock and asynchronous active-high reset
//   en        - advance the shift register by one stage
//   d         - lane input
//   q         - lane input delayed by STAGES enabled cycles
module skew_delay #(
  parameter int W      = 32,
  parameter int STAGES = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (STAGES == 0) begin : g_wire
      // Clock, reset and enable have no function without storage.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst, en};
      assign q = d;
    end else begin : g_shift
      logic [STAGES-1:0][W-1:0] stage;

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its neighbour's pre-edge value; blocking here would collapse
      // the whole line into a single stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage <= '0;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[STAGES-1];
    end
  endgenerate

endmodule : skew_delay

// File: rtl/psum_collector.sv
// psum_collector: deskews the bottom-row partial sums of the systolic array,
// accumulates them into a row buffer across K-tiles, and drains the buffer as
// aligned row vectors on the final tile.
//   clk, rst    - clock and asynchronous active-high reset
//   run         - array step enable; capture advances only when high
//   tile_start  - column 0 presents row 0 in this cycle (qualified by run)
//   num_rows    - rows in the tile, sampled at tile_start (1..DEPTH legal)
//   accumulate  - sampled at tile_start: add into buffer (1) or overwrite (0)
//   last_tile   - sampled at tile_start: drain the buffer after capture
//   acc_in      - per-column bottom-row acc_out, skewed by column index
//   out_valid   - a buffered row is presented
//   out_ready   - consumer accepts the presented row
//   out_data    - aligned row vector
//   out_last    - presented row is the final row of the tile
//   busy        - collector is not idle
module psum_collector #(
  parameter int COLS  = 4,
  parameter int DEPTH = 16,
  parameter int ACC_W = tpu_pkg::ACC_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            run,
  input  logic                            tile_start,
  input  logic [$clog2(DEPTH+1)-1:0]      num_rows,
  input  logic                            accumulate,
  input  logic                            last_tile,
  input  logic [COLS-1:0][ACC_W-1:0]      acc_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COLS-1:0][ACC_W-1:0]      out_data,
  output logic                            out_last,
  output logic                            busy
);

  import tpu_pkg::*;

  localparam int NR_W  = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Holds the largest run-cycle index of a tile, DEPTH+COLS-2.
  localparam int CNT_W = $clog2(DEPTH + COLS);
  localparam logic [CNT_W-1:0] SKEW = CNT_W'(COLS - 1);

  psum_state_e                  state;
  logic [NR_W-1:0]              nr_q;
  logic                         acc_q;
  logic                         last_q;
  logic [CNT_W-1:0]             cnt;
  logic [AW-1:0]                rd_ptr;

  logic [COLS-1:0][ACC_W-1:0]   lane;
  logic [COLS-1:0][ACC_W-1:0]   row_buf [DEPTH];

  logic                         start_ok;
  logic                         step;
  logic [CNT_W-1:0]             cyc;
  logic [NR_W-1:0]              nr_eff;
  logic [CNT_W-1:0]             nr_ext;
  logic                         acc_eff;
  logic                         wr_en;
  logic [AW-1:0]                wr_row;
  logic                         cap_done;
  logic                         drain_last;

  // ---------------------------------------------------------------------------
  // Deskew: lane c is delayed by COLS-1-c run-cycles so every lane carries
  // row r at run-cycle r+COLS-1. The lines shift on every run cycle in any
  // state; only the capture window decides whether their outputs are used.
  // ---------------------------------------------------------------------------
  generate
    for (genvar c = 0; c < COLS; c++) begin : g_lane
      skew_delay #(
        .W      (ACC_W),
        .STAGES (COLS - 1 - c)
      ) u_delay (
        .clk (clk),
        .rst (rst),
        .en  (run),
        .d   (acc_in[c]),
        .q   (lane[c])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Capture window decode. The accepted start cycle is run-cycle 0 and is
  // still spent in IDLE, so the tile parameters are taken straight from the
  // inputs in that cycle; this lets COLS == 1 write row 0 on the start cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every signal in this block is assigned before any condition reads
  // it, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    start_ok = (state == IDLE) && tile_start && run &&
               (num_rows != '0) && (num_rows <= NR_W'(DEPTH));
    step     = start_ok || ((state == CAPTURE) && run);
    cyc      = (state == CAPTURE) ? cnt : '0;
    nr_eff   = start_ok ? num_rows   : nr_q;
    acc_eff  = start_ok ? accumulate : acc_q;
    nr_ext   = CNT_W'(nr_eff);
    wr_en    = step && (cyc >= SKEW) && ((cyc - SKEW) < nr_ext);
    wr_row   = AW'(cyc - SKEW);
    // Final run-cycle of the tile is num_rows+COLS-2.
    cap_done = step && (cyc == nr_ext + SKEW - CNT_W'(1));
  end

  assign drain_last = (NR_W'(rd_ptr) == nr_q - NR_W'(1));

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      nr_q   <= '0;
      acc_q  <= 1'b0;
      last_q <= 1'b0;
      cnt    <= '0;
      rd_ptr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            nr_q   <= num_rows;
            acc_q  <= accumulate;
            last_q <= last_tile;
            rd_ptr <= '0;
            if (cap_done) begin
              state <= last_tile ? DRAIN : IDLE;
              cnt   <= '0;
            end else begin
              state <= CAPTURE;
              // Run-cycle 0 is this start cycle; the next one is cycle 1.
              cnt   <= CNT_W'(1);
            end
          end
        end

        CAPTURE: begin
          if (cap_done) begin
            state  <= last_q ? DRAIN : IDLE;
            cnt    <= '0;
            rd_ptr <= '0;
          end else if (run) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (drain_last) begin
              state  <= IDLE;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Row buffer: flop array so the drain side can read it combinationally.
  // Only rows inside the capture window are ever written.
  // ---------------------------------------------------------------------------
  // NOTE: the buffer is cleared by reset because accumulation reads it back;
  // a RAM-style unreset array would feed X into the first accumulating tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        row_buf[r] <= '0;
      end
    end else if (wr_en) begin
      for (int c = 0; c < COLS; c++) begin
        // Modulo-2^ACC_W wrap; no saturation.
        row_buf[wr_row][c] <= acc_eff ? (row_buf[wr_row][c] + lane[c]) : lane[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of the state and pointer registers, so they are
  // glitch-free, drop immediately on reset and hold while backpressured.
  // ---------------------------------------------------------------------------
  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign out_last  = (state == DRAIN) && drain_last;
  assign out_data  = (state == DRAIN) ? row_buf[rd_ptr] : '0;

endmodule : psum_collector

// File: tb/tb_psum_collector.sv
// tb_psum_collector: self-checking bench for psum_collector. A row-level
// buffer model (plain arrays, wrap-around addition) predicts every drained row.
module tb_psum_collector;

  localparam int COLS  = 4;
  localparam int DEPTH = 16;
  localparam int ACC_W = 32;
  localparam int NR_W  = $clog2(DEPTH + 1);

  logic                        clk;
  logic                        rst;
  logic                        run;
  logic                        tile_start;
  logic [NR_W-1:0]             num_rows;
  logic                        accumulate;
  logic                        last_tile;
  logic [COLS-1:0][ACC_W-1:0]  acc_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [COLS-1:0][ACC_W-1:0]  out_data;
  logic                        out_last;
  logic                        busy;

  int checks = 0;
  int errors = 0;

  // Tile contents in row/column form and the expected buffer contents.
  logic [ACC_W-1:0] tile_data [DEPTH][COLS];
  logic [ACC_W-1:0] model_buf [DEPTH][COLS];

  psum_collector #(
    .COLS  (COLS),
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .tile_start (tile_start),
    .num_rows   (num_rows),
    .accumulate (accumulate),
    .last_tile  (last_tile),
    .acc_in     (acc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------------
  task automatic model_clear();
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++)
        model_buf[r][c] = '0;
  endtask

  task automatic model_apply(input int nr, input bit acc);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < COLS; c++)
        model_buf[r][c] = acc ? (model_buf[r][c] + tile_data[r][c]) : tile_data[r][c];
  endtask

  task automatic fill_const(input logic [ACC_W-1:0] v);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++)
        tile_data[r][c] = v;
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++)
        tile_data[r][c] = ACC_W'(10 * r + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++)
        tile_data[r][c] = $urandom;
  endtask

  // ---------------------------------------------------------------------------
  // Drive one tile in array order: column c presents row r at run-cycle r+c.
  // Called and returns at a falling edge. stall_at < 0 means no stall.
  // noise scrambles tile_start/num_rows/flags after the start cycle.
  // ---------------------------------------------------------------------------
  task automatic drive_tile(input int nr, input bit acc, input bit last,
                            input int stall_at, input int stall_len, input bit noise);
    int t      = 0;
    int stalls = 0;
    int total  = nr + COLS - 1;
    while (t < total) begin
      if (t == stall_at && stalls < stall_len) begin
        run        = 1'b0;
        tile_start = noise ? 1'($urandom) : 1'b0;
        for (int c = 0; c < COLS; c++) acc_in[c] = $urandom;
        stalls++;
      end else begin
        run = 1'b1;
        if (t == 0) begin
          tile_start = 1'b1;
          num_rows   = NR_W'(nr);
          accumulate = acc;
          last_tile  = last;
        end else if (noise) begin
          tile_start = 1'($urandom);
          num_rows   = NR_W'($urandom_range(1, DEPTH));
          accumulate = 1'($urandom);
          last_tile  = 1'($urandom);
        end else begin
          tile_start = 1'b0;
        end
        for (int c = 0; c < COLS; c++) begin
          int r = t - c;
          acc_in[c] = (r >= 0 && r < nr) ? tile_data[r][c] : ACC_W'($urandom);
        end
        t++;
      end
      @(negedge clk);
      if (t < total) begin
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0)
          $display("FAIL capture_state: busy=%b out_valid=%b required busy=1 out_valid=0 (run-cycle %0d)",
                   busy, out_valid, t);
      end
      if (t < total && (busy !== 1'b1 || out_valid !== 1'b0)) errors++;
    end
    run        = 1'b0;
    tile_start = 1'b0;
    for (int c = 0; c < COLS; c++) acc_in[c] = $urandom;
    model_apply(nr, acc);
    checks++;
    if (out_valid !== last || busy !== last) begin
      errors++;
      $display("FAIL capture_end: out_valid=%b busy=%b required both %b", out_valid, busy, last);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drain nr rows against the model. abort_at >= 0 asserts reset once that
  // many rows have been accepted. Returns at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic drain(input int nr, input bit rand_ready, input bit noise, input int abort_at);
    int idx   = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic [COLS-1:0][ACC_W-1:0] held;
    logic                       held_last;
    logic [COLS-1:0][ACC_W-1:0] exp_row;
    held      = '0;
    held_last = 1'b0;
    while (idx < nr && guard < 2000) begin
      guard++;
      if (abort_at >= 0 && idx == abort_at) begin
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_drain: out_valid=%b busy=%b out_last=%b required all 0",
                   out_valid, busy, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        return;
      end
      for (int c = 0; c < COLS; c++) exp_row[c] = model_buf[idx][c];
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_valid: row %0d out_valid=%b required 1", idx, out_valid);
      end
      checks++;
      if (out_data !== exp_row) begin
        errors++;
        $display("FAIL drain_data: row %0d got %h required %h", idx, out_data, exp_row);
      end
      checks++;
      if (out_last !== (idx == nr - 1)) begin
        errors++;
        $display("FAIL drain_last: row %0d out_last=%b required %b", idx, out_last, idx == nr - 1);
      end
      if (stalled) begin
        checks++;
        if (out_data !== held || out_last !== held_last) begin
          errors++;
          $display("FAIL drain_hold: row %0d got %h/%b required %h/%b while stalled",
                   idx, out_data, out_last, held, held_last);
        end
      end
      out_ready = rand_ready ? 1'($urandom) : 1'b1;
      if (noise) begin
        tile_start = 1'($urandom);
        run        = 1'($urandom);
        num_rows   = NR_W'($urandom_range(1, DEPTH));
        accumulate = 1'($urandom);
        last_tile  = 1'($urandom);
      end
      held      = out_data;
      held_last = out_last;
      stalled   = !out_ready;
      if (out_ready) idx++;
      @(negedge clk);
    end
    out_ready  = 1'b0;
    tile_start = 1'b0;
    run        = 1'b0;
    if (idx < nr) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: accepted %0d rows required %0d", idx, nr);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b last=%b busy=%b data=%h required all 0",
               out_valid, out_last, busy, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_release: valid=%b busy=%b data=%h required all 0",
               out_valid, busy, out_data);
    end
    model_clear();
  endtask

  task automatic test_single_overwrite();
    fill_pattern();
    drive_tile(3, 1'b0, 1'b1, -1, 0, 1'b0);
    drain(3, 1'b0, 1'b0, -1);
  endtask

  task automatic test_two_tile_accum();
    fill_const(ACC_W'(5));
    drive_tile(4, 1'b0, 1'b0, -1, 0, 1'b0);
    fill_const(ACC_W'(7));
    drive_tile(4, 1'b1, 1'b1, -1, 0, 1'b0);
    checks++;
    if (model_buf[0][0] !== ACC_W'(12) || model_buf[3][COLS-1] !== ACC_W'(12)) begin
      errors++;
      $display("FAIL accum_model: got %0d required 12", model_buf[0][0]);
    end
    drain(4, 1'b0, 1'b0, -1);
  endtask

  task automatic test_wrap();
    fill_const(32'hFFFF_FFFF);
    drive_tile(2, 1'b0, 1'b0, -1, 0, 1'b0);
    fill_const(ACC_W'(2));
    drive_tile(2, 1'b1, 1'b1, -1, 0, 1'b0);
    checks++;
    if (out_data[0] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL wrap_lane0: got %h required 00000001", out_data[0]);
    end
    drain(2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stall_backpressure();
    fill_pattern();
    drive_tile(3, 1'b0, 1'b1, 3, 3, 1'b0);
    drain(3, 1'b1, 1'b0, -1);
  endtask

  task automatic test_illegal_starts();
    run        = 1'b1;
    tile_start = 1'b1;
    num_rows   = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_rows0: busy=%b required 0", busy);
    end
    num_rows = NR_W'(DEPTH + 1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_rows_over: busy=%b required 0", busy);
    end
    run      = 1'b0;
    num_rows = NR_W'(4);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_no_run: busy=%b required 0", busy);
    end
    tile_start = 1'b0;
    // Starts during capture and drain must leave the tile untouched.
    fill_random();
    drive_tile(6, 1'b0, 1'b1, -1, 0, 1'b1);
    drain(6, 1'b1, 1'b1, -1);
  endtask

  task automatic test_reset_mid_drain();
    fill_random();
    drive_tile(4, 1'b0, 1'b1, -1, 0, 1'b0);
    drain(4, 1'b0, 1'b0, 2);
    // Accumulating onto the cleared buffer must yield the raw tile.
    fill_random();
    drive_tile(5, 1'b1, 1'b1, -1, 0, 1'b0);
    drain(5, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back_random();
    for (int k = 0; k < 14; k++) begin
      int nr;
      bit acc;
      bit last;
      int stall_at;
      nr   = (k == 0) ? 1 : (k == 1) ? DEPTH : int'($urandom_range(1, DEPTH));
      acc  = 1'($urandom);
      last = (k == 13) ? 1'b1 : 1'($urandom);
      stall_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, nr + COLS - 2)) : -1;
      fill_random();
      drive_tile(nr, acc, last, stall_at, int'($urandom_range(1, 3)), 1'b1);
      if (last) drain(nr, 1'b1, 1'b1, -1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b0;
    tile_start = 1'b0;
    num_rows   = '0;
    accumulate = 1'b0;
    last_tile  = 1'b0;
    acc_in     = '0;
    out_ready  = 1'b0;

    test_reset();
    test_single_overwrite();
    test_two_tile_accum();
    test_wrap();
    test_stall_backpressure();
    test_illegal_starts();
    test_reset_mid_drain();
    test_back_to_back_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_psum_collector
